// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Build option MIPS_MC_CTRL_PERF_EN (see top level) does not affect this package.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b101;
    localparam logic [2:0] ALU_ORI   = 3'b110;
    localparam logic [2:0] ALU_SLTIU = 3'b111;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BLE  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLTZ = 3'b011;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] branch_type;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] branch_type_of(input logic [5:0] op);
        case (op)
            OP_BEQ:    return BR_BEQ;
            OP_BLEZ:   return BR_BLE;
            OP_BNE:    return BR_BNE;
            OP_REGIMM: return BR_BLTZ;
            default:   return BR_BEQ;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_out.sv
// Combinational decode of the controller state (plus opcode and memory
// handshake) into datapath enables and selects; everything is 0 under reset.
module mips_mc_ctrl_out
    import mips_mc_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state output map
    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl = '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_src    = PC_SRC_ALU;
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end else begin
                        ctrl.ir_write = 1'b0;
                        ctrl.pc_write = 1'b0;
                    end
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.illegal   = ~op_legal(op);
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_dst    = DST_RD;
                    ctrl.mem_to_reg = WB_ALUOUT;
                    ctrl.reg_write  = 1'b1;
                end
                S_I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    case (op)
                        OP_ADDI, OP_LUI: ctrl.alu_op = ALU_ADDI;
                        OP_SLTIU:        ctrl.alu_op = ALU_SLTIU;
                        OP_ORI:          ctrl.alu_op = ALU_ORI;
                        default:         ctrl.alu_op = ALU_ADD;
                    endcase
                end
                S_I_WB: begin
                    ctrl.reg_dst    = DST_RT;
                    ctrl.mem_to_reg = WB_ALUOUT;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_dst    = DST_RT;
                    ctrl.mem_to_reg = WB_MDR;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_RT;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_src        = PC_SRC_ALUOUT;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.branch_type   = branch_type_of(op);
                end
                S_JUMP: begin
                    ctrl.pc_src   = PC_SRC_JUMP;
                    ctrl.pc_write = 1'b1;
                    if (op == OP_JAL) begin
                        ctrl.reg_dst    = DST_RA;
                        ctrl.mem_to_reg = WB_PC;
                        ctrl.reg_write  = 1'b1;
                    end else begin
                        ctrl.reg_write  = 1'b0;
                    end
                end
                S_JR: begin
                    ctrl.pc_src   = PC_SRC_RS;
                    ctrl.pc_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and optional
// perf counters (build option MIPS_MC_CTRL_PERF_EN).
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  instr_op_i,
    input  logic [5:0]  funct_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic [2:0]  branch_type_o,
    output logic [1:0]  pc_src_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [1:0]  reg_dst_o,
    output logic [1:0]  mem_to_reg_o,
    output logic        reg_write_o,
    output logic        illegal_o,
`ifdef MIPS_MC_CTRL_PERF_EN
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o,
`endif
    output logic [3:0]  state_o
);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_s;

    // Next-state sequencing; IR fields are valid from DECODE onward
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready_i) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (instr_op_i)
                    OP_RTYPE: begin
                        if (funct_i == FN_NOP) begin
                            next_state_s = S_FETCH;
                        end else if (funct_i == FN_JR) begin
                            next_state_s = S_JR;
                        end else begin
                            next_state_s = S_R_EXEC;
                        end
                    end
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_REGIMM:  next_state_s = S_BRANCH;
                    OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:   next_state_s = S_I_EXEC;
                    OP_LW, OP_SW:                        next_state_s = S_MEM_ADDR;
                    OP_J, OP_JAL:                        next_state_s = S_JUMP;
                    default:                             next_state_s = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (instr_op_i == OP_SW) begin
                    next_state_s = S_MEM_WR;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_R_EXEC: next_state_s = S_R_WB;
            S_I_EXEC: next_state_s = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    mips_mc_ctrl_out u_ctrl_out (
        .rst       (rst_i),
        .state     (state_r),
        .op        (instr_op_i),
        .mem_ready (mem_ready_i),
        .ctrl      (ctrl_s)
    );

    assign pc_write_o      = ctrl_s.pc_write;
    assign pc_write_cond_o = ctrl_s.pc_write_cond;
    assign branch_type_o   = ctrl_s.branch_type;
    assign pc_src_o        = ctrl_s.pc_src;
    assign iord_o          = ctrl_s.iord;
    assign mem_read_o      = ctrl_s.mem_read;
    assign mem_write_o     = ctrl_s.mem_write;
    assign ir_write_o      = ctrl_s.ir_write;
    assign alu_src_a_o     = ctrl_s.alu_src_a;
    assign alu_src_b_o     = ctrl_s.alu_src_b;
    assign alu_op_o        = ctrl_s.alu_op;
    assign reg_dst_o       = ctrl_s.reg_dst;
    assign mem_to_reg_o    = ctrl_s.mem_to_reg;
    assign reg_write_o     = ctrl_s.reg_write;
    assign illegal_o       = ctrl_s.illegal;
    assign state_o         = state_r;

`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] instr_cnt_r;

    // Free-running cycle count and retired-instruction count (entries into FETCH)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_r <= 32'd0;
            instr_cnt_r <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if ((next_state_s == S_FETCH) && (state_r != S_FETCH)) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_r;
    assign instr_cnt_o = instr_cnt_r;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, cycle-by-cycle bench for mips_multicycle_ctrl with hand-derived
// control words per state; perf counters checked when MIPS_MC_CTRL_PERF_EN is set.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       alu_src_a, reg_write, illegal;
    logic [2:0] branch_type, alu_op;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [3:0] state;
`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif
    int n_cmp = 0;
    int n_err = 0;

    mips_multicycle_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_op_i      (op),
        .funct_i         (fn),
        .mem_ready_i     (rdy),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .branch_type_o   (branch_type),
        .pc_src_o        (pc_src),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .reg_write_o     (reg_write),
        .illegal_o       (illegal),
`ifdef MIPS_MC_CTRL_PERF_EN
        .cycle_cnt_o     (cycle_cnt),
        .instr_cnt_o     (instr_cnt),
`endif
        .state_o         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcw, pcwc, btype[3], pcsrc[2], iord, mrd, mwr, irw, srca, srcb[2], aluop[3], rdst[2], m2r[2], rw, ill}
    logic [22:0] obs;
    assign obs = {pc_write, pc_write_cond, branch_type, pc_src, iord, mem_read, mem_write,
                  ir_write, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal};

    localparam logic [22:0] ZERO    = 23'd0;
    localparam logic [22:0] F_WAIT  = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] F_RDY   = {1'b1,1'b0,3'b000,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b01,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] DEC     = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] DEC_ILL = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,2'b00,1'b0,1'b1};
    localparam logic [22:0] R_EX    = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] R_WB    = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b01,2'b00,1'b1,1'b0};
    localparam logic [22:0] I_ADDI  = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b101,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] I_ORI   = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b110,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] I_SLTIU = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b111,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] I_WB    = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b1,1'b0};
    localparam logic [22:0] MA      = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] MRD     = {1'b0,1'b0,3'b000,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] MWB     = {1'b0,1'b0,3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b01,1'b1,1'b0};
    localparam logic [22:0] MWR     = {1'b0,1'b0,3'b000,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] BR_BEQ  = {1'b0,1'b1,3'b000,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] BR_BLE  = {1'b0,1'b1,3'b001,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] BR_BNE  = {1'b0,1'b1,3'b010,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] BR_BLTZ = {1'b0,1'b1,3'b011,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] JMP     = {1'b1,1'b0,3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b0};
    localparam logic [22:0] JAL     = {1'b1,1'b0,3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,2'b11,1'b1,1'b0};
    localparam logic [22:0] JR      = {1'b1,1'b0,3'b000,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0,1'b0};

    task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
        op = o;
        fn = f;
    endtask

    // One clock: drive ready, check state and control word mid-cycle, advance
    task automatic cyc(input string tag, input logic r, input logic [3:0] es, input logic [22:0] ew);
        rdy = r;
        @(negedge clk);
        n_cmp++;
        assert (state === es) else begin
            n_err++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, es);
        end
        n_cmp++;
        assert (obs === ew) else begin
            n_err++;
            $error("FAIL %s ctrl: got %b expected %b", tag, obs, ew);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] ecyc, input logic [31:0] einstr);
`ifdef MIPS_MC_CTRL_PERF_EN
        n_cmp++;
        assert (cycle_cnt === ecyc) else begin
            n_err++;
            $error("FAIL %s cycle_cnt: got %0d expected %0d", tag, cycle_cnt, ecyc);
        end
        n_cmp++;
        assert (instr_cnt === einstr) else begin
            n_err++;
            $error("FAIL %s instr_cnt: got %0d expected %0d", tag, instr_cnt, einstr);
        end
`else
        if (ecyc == einstr) begin
            tag = "";
        end else begin
            tag = "";
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        set_ir(6'h00, 6'h00);
        @(posedge clk);
        #1;
        cyc("rst_hold", 1'b1, 4'd0, ZERO);
        rst = 1'b0;

        // illegal opcode pulses for one DECODE cycle
        set_ir(6'h3F, 6'h00);
        cyc("ill_f", 1'b1, 4'd0, F_RDY);
        cyc("ill_d", 1'b1, 4'd1, DEC_ILL);
        chk_perf("ill_perf", 32'd2, 32'd1);

        set_ir(6'h00, 6'h00);
        cyc("nop_f", 1'b1, 4'd0, F_RDY);
        cyc("nop_d", 1'b1, 4'd1, DEC);

        // add, with one fetch stall cycle first
        set_ir(6'h00, 6'h20);
        cyc("add_fw", 1'b0, 4'd0, F_WAIT);
        cyc("add_f",  1'b1, 4'd0, F_RDY);
        cyc("add_d",  1'b1, 4'd1, DEC);
        cyc("add_ex", 1'b1, 4'd6, R_EX);
        cyc("add_wb", 1'b1, 4'd7, R_WB);

        // lw with two wait cycles in MEM_RD
        set_ir(6'h23, 6'h00);
        cyc("lw_f",   1'b1, 4'd0, F_RDY);
        cyc("lw_d",   1'b1, 4'd1, DEC);
        cyc("lw_ma",  1'b1, 4'd2, MA);
        cyc("lw_rd0", 1'b0, 4'd3, MRD);
        cyc("lw_rd1", 1'b0, 4'd3, MRD);
        cyc("lw_rd2", 1'b1, 4'd3, MRD);
        cyc("lw_wb",  1'b1, 4'd4, MWB);

        set_ir(6'h08, 6'h00);
        cyc("addi_f", 1'b1, 4'd0, F_RDY);
        cyc("addi_d", 1'b1, 4'd1, DEC);
        cyc("addi_x", 1'b1, 4'd8, I_ADDI);
        cyc("addi_w", 1'b1, 4'd9, I_WB);
        set_ir(6'h0D, 6'h00);
        cyc("ori_f", 1'b1, 4'd0, F_RDY);
        cyc("ori_d", 1'b1, 4'd1, DEC);
        cyc("ori_x", 1'b1, 4'd8, I_ORI);
        cyc("ori_w", 1'b1, 4'd9, I_WB);
        set_ir(6'h0B, 6'h00);
        cyc("sltiu_f", 1'b1, 4'd0, F_RDY);
        cyc("sltiu_d", 1'b1, 4'd1, DEC);
        cyc("sltiu_x", 1'b1, 4'd8, I_SLTIU);
        cyc("sltiu_w", 1'b1, 4'd9, I_WB);
        set_ir(6'h0F, 6'h00);
        cyc("li_f", 1'b1, 4'd0, F_RDY);
        cyc("li_d", 1'b1, 4'd1, DEC);
        cyc("li_x", 1'b1, 4'd8, I_ADDI);
        cyc("li_w", 1'b1, 4'd9, I_WB);

        set_ir(6'h05, 6'h00);
        cyc("bne_f", 1'b1, 4'd0, F_RDY);
        cyc("bne_d", 1'b1, 4'd1, DEC);
        cyc("bne_b", 1'b1, 4'd10, BR_BNE);
        set_ir(6'h04, 6'h00);
        cyc("beq_f", 1'b1, 4'd0, F_RDY);
        cyc("beq_d", 1'b1, 4'd1, DEC);
        cyc("beq_b", 1'b1, 4'd10, BR_BEQ);
        set_ir(6'h06, 6'h00);
        cyc("ble_f", 1'b1, 4'd0, F_RDY);
        cyc("ble_d", 1'b1, 4'd1, DEC);
        cyc("ble_b", 1'b1, 4'd10, BR_BLE);
        set_ir(6'h01, 6'h00);
        cyc("bltz_f", 1'b1, 4'd0, F_RDY);
        cyc("bltz_d", 1'b1, 4'd1, DEC);
        cyc("bltz_b", 1'b1, 4'd10, BR_BLTZ);

        set_ir(6'h02, 6'h00);
        cyc("j_f", 1'b1, 4'd0, F_RDY);
        cyc("j_d", 1'b1, 4'd1, DEC);
        cyc("j_j", 1'b1, 4'd11, JMP);
        set_ir(6'h03, 6'h00);
        cyc("jal_f", 1'b1, 4'd0, F_RDY);
        cyc("jal_d", 1'b1, 4'd1, DEC);
        cyc("jal_j", 1'b1, 4'd11, JAL);
        set_ir(6'h00, 6'h08);
        cyc("jr_f", 1'b1, 4'd0, F_RDY);
        cyc("jr_d", 1'b1, 4'd1, DEC);
        cyc("jr_j", 1'b1, 4'd12, JR);

        // sw with one wait cycle, write strobe held during the wait
        set_ir(6'h2B, 6'h00);
        cyc("sw_f",   1'b1, 4'd0, F_RDY);
        cyc("sw_d",   1'b1, 4'd1, DEC);
        cyc("sw_ma",  1'b1, 4'd2, MA);
        cyc("sw_wr0", 1'b0, 4'd5, MWR);
        cyc("sw_wr1", 1'b1, 4'd5, MWR);

        // second sw, reset for 3 cycles while the write is pending
        cyc("sw2_f",  1'b1, 4'd0, F_RDY);
        cyc("sw2_d",  1'b1, 4'd1, DEC);
        cyc("sw2_ma", 1'b1, 4'd2, MA);
        cyc("sw2_wr", 1'b0, 4'd5, MWR);
        rst = 1'b1;
        cyc("rst_mwr0", 1'b0, 4'd5, ZERO);
        cyc("rst_mwr1", 1'b0, 4'd0, ZERO);
        cyc("rst_mwr2", 1'b0, 4'd0, ZERO);
        rst = 1'b0;
        chk_perf("rst_perf", 32'd0, 32'd0);
        set_ir(6'h00, 6'h00);
        cyc("post_f", 1'b1, 4'd0, F_RDY);
        cyc("post_d", 1'b1, 4'd1, DEC);
        cyc("post_f2", 1'b0, 4'd0, F_WAIT);
        chk_perf("post_perf", 32'd3, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS core. It replaces single-cycle decode with a sequenced controller that shares one ALU and one unified memory port across FETCH, DECODE, EXEC, MEM and WB steps. It latches no data; it reads the opcode and funct fields from the datapath's instruction register and drives all datapath enables and mux selects. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- instr_op_i  in  6  IR[31:26]
- funct_i  in  6  IR[5:0]
- mem_ready_i  in  1  memory completes the access this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if datapath branch compare passes
- branch_type_o  out  3  000 beq, 001 ble, 010 bne, 011 bltz
- pc_src_o  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
- iord_o  out  1  0 = PC address, 1 = ALUOut address
- mem_read_o / mem_write_o  out  1  memory strobes
- ir_write_o  out  1  IR load
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
- alu_op_o  out  3  000 add, 001 sub, 010 funct, 101 addi/li, 110 ori, 111 sltiu
- reg_dst_o  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 11 PC
- reg_write_o  out  1  register file write
- illegal_o  out  1  one-cycle pulse on an undefined opcode
- state_o  out  4  current state, for debug

## Operation
- The state encodings are: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JR 12.
- **FETCH:** iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00. When mem_ready_i=1: ir_write=1, pc_write=1, and the next state is DECODE. Otherwise the FSM stays in FETCH with both write enables 0.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=000 (precompute the branch target). The next state depends on the opcode:
  - 0x00 with funct 0x00 (nop) goes to FETCH.
  - 0x00 with funct 0x08 goes to JR.
  - Any other 0x00 goes to R_EXEC.
  - 0x04, 0x05, 0x06, 0x01 go to BRANCH.
  - 0x08, 0x0B, 0x0D, 0x0F go to I_EXEC.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x02 and 0x03 go to JUMP.
  - Any other opcode pulses illegal_o and goes to FETCH.
- **R_EXEC:** alu_src_a=1, alu_src_b=00, alu_op=010. Next state is R_WB.
- **R_WB:** reg_dst=01, mem_to_reg=00, reg_write=1. Next state is FETCH.
- **I_EXEC:** alu_src_a=1, alu_src_b=10. alu_op is 101 for 0x08/0x0F, 111 for 0x0B, 110 for 0x0D. Next state is I_WB.
- **I_WB:** reg_dst=00, mem_to_reg=00, reg_write=1. Next state is FETCH.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_op=000. The next state is MEM_RD for 0x23 and MEM_WR for 0x2B.
- **MEM_RD:** iord=1, mem_read=1. Stays in MEM_RD until mem_ready_i, then goes to MEM_WB.
- **MEM_WB:** reg_dst=00, mem_to_reg=01, reg_write=1. Next state is FETCH.
- **MEM_WR:** iord=1, mem_write=1. Stays in MEM_WR until mem_ready_i, then goes to FETCH. mem_write remains high throughout the wait.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_write_cond=1, branch_type from the opcode. Next state is FETCH.
- **JUMP:** pc_src=10, pc_write=1. For 0x03 the state also drives reg_dst=10, mem_to_reg=11, reg_write=1. Next state is FETCH.
- **JR:** pc_src=11, pc_write=1. Next state is FETCH.
- Every output not listed for a state is 0.

## Timing
- Outputs are Moore and decoded from the state register and the IR fields. The only exception is FETCH's ir_write/pc_write, which is gated by mem_ready_i.
- Cycle counts with mem_ready_i held at 1:
  - nop: 2 cycles.
  - branch, j, jal, jr: 3 cycles.
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle of mem_ready_i=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- **Reset:** while rst_i=1, the state is loaded with FETCH at every edge. pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write and illegal_o are forced to 0, and the selects are 0. After rst_i falls, the outputs take their FETCH values.
- **Reset mid-operation** (for example during MEM_WR with a pending write) abandons the access. The next state is FETCH, and mem_write is forced to 0 in the rst_i cycle.
- IR fields are stable from DECODE until the return to FETCH. The controller samples them freely in those states.

## Configuration
- The macro is `MIPS_MC_CTRL_PERF_EN`.
- **Defined:** adds two 32-bit outputs.
  - cycle_cnt_o increments every cycle that rst_i=0.
  - instr_cnt_o increments on every transition into FETCH from a non-FETCH state.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- **Undefined:** the ports and the counters do not exist.

## Structure
- **Package mips_mc_pkg:** state enum, opcode and funct constants, alu_op codes, branch_type codes, pc_src codes, alu_src_b codes.
- **Sub-module mips_mc_ctrl_out:** a purely combinational map from state, opcode and mem_ready to the datapath outputs. The top level holds only the state register, next-state logic and counters.

## Test plan
- Reset held for 3 cycles during MEM_WR: all strobes are 0 during reset; state_o=0 on the first cycle after release.
- add (op 0x00, funct 0x20) with mem_ready_i=1: states 0→1→6→7→0; reg_write=1 only in cycle 4 with reg_dst=01.
- lw (0x23) with mem_ready_i low for 2 cycles in MEM_RD: 7 cycles total; reg_write is asserted once with mem_to_reg=01.
- bne (0x05): BRANCH asserts pc_write_cond=1 and branch_type=010 for exactly 1 cycle; pc_write stays 0.
- jal (0x03): JUMP drives pc_write=1, reg_dst=10, mem_to_reg=11, reg_write=1; jr (funct 0x08) drives pc_src=11.
- Opcode 0x3F: illegal_o pulses for 1 cycle in DECODE, then FETCH; with `MIPS_MC_CTRL_PERF_EN`, instr_cnt_o increments by 1.
